rfphoenix_mcalu_issue: RTL and testbench

Issue scheduler directly upstream of the multi-cycle ALU. Accepts one request per cycle from the thread selector, checks that the request's thread has no multi-cycle op in flight and that the ALU result slot the op will occupy is free, then issues it with a registered strobe. A latency-reservation shift register tracks every in-flight op and produces a writeback strobe carrying the thread id in the exact cycle the ALU result is valid. No two results ever share a writeback cycle, even with mixed latencies.

---
 rtl/rfphoenix_mcalu_issue_if.sv | 29 ++
 rtl/rfphoenix_mcalu_issue.sv | 95 +++++++++
 tb/tb_rfphoenix_mcalu_issue.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rfphoenix_mcalu_issue_if.sv
// Request/issue/writeback bundle between the thread selector, the issue
// scheduler and the multi-cycle ALU.
interface rfphoenix_mcalu_issue_if #(
  parameter int NTHREADS = 8
);
  localparam int TIDW = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;

  logic                flush;
  logic                req_v;
  logic [TIDW-1:0]     req_tid;
  logic [1:0]          req_cls;
  logic                req_rdy;
  logic                iss_v;
  logic [TIDW-1:0]     iss_tid;
  logic [1:0]          iss_cls;
  logic                wb_v;
  logic [TIDW-1:0]     wb_tid;
  logic [NTHREADS-1:0] busy;

  modport master (
    output flush, req_v, req_tid, req_cls,
    input  req_rdy, iss_v, iss_tid, iss_cls, wb_v, wb_tid, busy
  );

  modport slave (
    input  flush, req_v, req_tid, req_cls,
    output req_rdy, iss_v, iss_tid, iss_cls, wb_v, wb_tid, busy
  );
endinterface

// File: rtl/rfphoenix_mcalu_issue.sv
// Issue scheduler for the multi-cycle ALU: per-thread in-flight blocking plus a
// latency-reservation shift register that guarantees one writeback per cycle.
module rfphoenix_mcalu_issue #(
  parameter int NTHREADS = 8,
  parameter int LAT_MUL  = 8,
  parameter int LAT_FMA  = 8,
  parameter int LAT_CVT  = 8,
  parameter int LAT_EST  = 6,
  parameter int MAXLAT   = 15
) (
  input logic clk,
  input logic rst,
  rfphoenix_mcalu_issue_if.slave bus
);
  localparam int TIDW  = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;
  localparam int DEPTH = MAXLAT + 2;
  localparam int LATW  = $clog2(DEPTH);

  logic [DEPTH-1:0]    res;
  logic [DEPTH-1:0]    res_nxt;
  logic [TIDW-1:0]     rtid     [DEPTH];
  logic [TIDW-1:0]     rtid_nxt [DEPTH];
  logic [NTHREADS-1:0] busy;
  logic [NTHREADS-1:0] busy_nxt;
  logic                iss_v;
  logic [TIDW-1:0]     iss_tid;
  logic [1:0]          iss_cls;

  logic [LATW-1:0]     lat;
  logic [LATW-1:0]     lat_p1;
  logic                tid_ok;
  logic                req_rdy;
  logic                accept;

  always_comb begin
    case (bus.req_cls)
      2'd0:    lat = LATW'(LAT_MUL);
      2'd1:    lat = LATW'(LAT_FMA);
      2'd2:    lat = LATW'(LAT_CVT);
      default: lat = LATW'(LAT_EST);
    endcase
  end

  // Slot lat+1 before this edge's shift is slot lat after it.
  assign lat_p1  = lat + LATW'(1);
  assign tid_ok  = int'(bus.req_tid) < NTHREADS;
  assign req_rdy = !bus.flush && tid_ok && !busy[bus.req_tid] && !res[lat_p1];
  assign accept  = bus.req_v && req_rdy;

  always_comb begin
    res_nxt = res >> 1;
    for (int i = 0; i < DEPTH - 1; i++) rtid_nxt[i] = rtid[i+1];
    rtid_nxt[DEPTH-1] = '0;
    busy_nxt = busy;
    if (res[0]) busy_nxt[rtid[0]] = 1'b0;
    // Set after the writeback clear so a different thread's accept survives.
    if (accept) begin
      res_nxt[lat]            = 1'b1;
      rtid_nxt[lat]           = bus.req_tid;
      busy_nxt[bus.req_tid]   = 1'b1;
    end
    if (bus.flush) begin
      res_nxt  = '0;
      busy_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res     <= '0;
      busy    <= '0;
      iss_v   <= 1'b0;
      iss_tid <= '0;
      iss_cls <= '0;
      for (int i = 0; i < DEPTH; i++) rtid[i] <= '0;
    end else begin
      res   <= res_nxt;
      busy  <= busy_nxt;
      iss_v <= accept;
      for (int i = 0; i < DEPTH; i++) rtid[i] <= rtid_nxt[i];
      if (accept) begin
        iss_tid <= bus.req_tid;
        iss_cls <= bus.req_cls;
      end
    end
  end

  assign bus.req_rdy = req_rdy;
  assign bus.iss_v   = iss_v;
  assign bus.iss_tid = iss_tid;
  assign bus.iss_cls = iss_cls;
  assign bus.wb_v    = res[0];
  assign bus.wb_tid  = rtid[0];
  assign bus.busy    = busy;
endmodule

// File: tb/tb_rfphoenix_mcalu_issue.sv
// Directed bench for the multi-cycle ALU issue scheduler.
module tb_rfphoenix_mcalu_issue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rfphoenix_mcalu_issue_if #(.NTHREADS(8)) bus ();
  rfphoenix_mcalu_issue dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [2:0] tid;
    logic [1:0] cls;
    int         lat;
  } lat_vec_t;

  lat_vec_t   vecs [5];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  int         wb_cnt;
  int         wb_at;
  logic [2:0] wb_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] tid, input logic [1:0] cls, input logic fl);
    bus.req_v   = v;
    bus.req_tid = tid;
    bus.req_cls = cls;
    bus.flush   = fl;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 3'd0, 2'd0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'd2, 2'd0, 8};
    vecs[1] = '{3'd5, 2'd1, 8};
    vecs[2] = '{3'd7, 2'd2, 8};
    vecs[3] = '{3'd0, 2'd3, 6};
    vecs[4] = '{3'd3, 2'd3, 6};

    drive(1'b0, 3'd0, 2'd0, 1'b0);

    // reset state
    do_reset();
    smp();
    chk("rst_iss_v",   bus.iss_v,   0);
    chk("rst_iss_tid", bus.iss_tid, 0);
    chk("rst_iss_cls", bus.iss_cls, 0);
    chk("rst_wb_v",    bus.wb_v,    0);
    chk("rst_wb_tid",  bus.wb_tid,  0);
    chk("rst_busy",    bus.busy,    0);
    chk("rst_rdy",     bus.req_rdy, 1);

    // single-op latency per class
    for (int k = 0; k < 5; k++) begin
      do_reset();
      drive(1'b1, vecs[k].tid, vecs[k].cls, 1'b0);
      smp();
      chk("lat_rdy", bus.req_rdy, 1);
      next_cyc();
      drive(1'b0, 3'd0, 2'd0, 1'b0);
      smp();
      chk("lat_iss_v",    bus.iss_v,   1);
      chk("lat_iss_tid",  bus.iss_tid, vecs[k].tid);
      chk("lat_iss_cls",  bus.iss_cls, vecs[k].cls);
      chk("lat_busy_set", bus.busy,    32'd1 << vecs[k].tid);
      wb_cnt = 0;
      wb_at  = 0;
      wb_t   = 3'd0;
      while (cyc < vecs[k].lat + 5) begin
        next_cyc();
        smp();
        if (bus.wb_v) begin
          wb_cnt++;
          wb_at = cyc;
          wb_t  = bus.wb_tid;
        end
        if (cyc == 3) chk("lat_iss_drop", bus.iss_v, 0);
        if (cyc == vecs[k].lat + 2) chk("lat_busy_wb", bus.busy, 32'd1 << vecs[k].tid);
        if (cyc == vecs[k].lat + 3) chk("lat_busy_clr", bus.busy, 0);
      end
      chk("lat_wb_cnt", wb_cnt, 1);
      chk("lat_wb_cyc", wb_at,  vecs[k].lat + 2);
      chk("lat_wb_tid", wb_t,   vecs[k].tid);
    end

    // back-to-back, threads 0..7, class 1
    do_reset();
    while (cyc <= 18) begin
      drive(cyc <= 8, 3'(cyc - 1), 2'd1, 1'b0);
      smp();
      if (cyc <= 8) chk("b2b_rdy", bus.req_rdy, 1);
      chk("b2b_iss_v", bus.iss_v, (cyc >= 2 && cyc <= 9));
      if (cyc >= 2 && cyc <= 9) chk("b2b_iss_tid", bus.iss_tid, cyc - 2);
      chk("b2b_wb_v", bus.wb_v, (cyc >= 10 && cyc <= 17));
      if (cyc >= 10 && cyc <= 17) chk("b2b_wb_tid", bus.wb_tid, cyc - 10);
      next_cyc();
    end

    // class-3 op colliding with an earlier class-0 slot
    do_reset();
    while (cyc <= 13) begin
      case (cyc)
        1:       drive(1'b1, 3'd1, 2'd0, 1'b0);
        3, 4:    drive(1'b1, 3'd3, 2'd3, 1'b0);
        default: drive(1'b0, 3'd0, 2'd0, 1'b0);
      endcase
      smp();
      if (cyc == 1) chk("cf_rdy1", bus.req_rdy, 1);
      if (cyc == 3) chk("cf_rdy3", bus.req_rdy, 0);
      if (cyc == 4) chk("cf_rdy4", bus.req_rdy, 1);
      if (cyc == 4) chk("cf_iss4", bus.iss_v, 0);
      if (cyc == 5) chk("cf_iss5_tid", {bus.iss_v, bus.iss_tid, bus.iss_cls}, {1'b1, 3'd3, 2'd3});
      chk("cf_wb_v", bus.wb_v, (cyc == 10 || cyc == 11));
      if (cyc == 10) chk("cf_wb_tid10", bus.wb_tid, 1);
      if (cyc == 11) chk("cf_wb_tid11", bus.wb_tid, 3);
      next_cyc();
    end

    // same thread held until its first op writes back
    do_reset();
    while (cyc <= 11) begin
      drive(cyc <= 9, 3'd4, 2'd3, 1'b0);
      smp();
      if (cyc <= 9) chk("st_rdy", bus.req_rdy, (cyc == 1 || cyc == 9));
      chk("st_iss_v", bus.iss_v, (cyc == 2 || cyc == 10));
      chk("st_wb_v",  bus.wb_v,  (cyc == 8));
      if (cyc == 8) chk("st_wb_tid", bus.wb_tid, 4);
      if (cyc == 9) chk("st_busy9", bus.busy, 0);
      next_cyc();
    end

    // flush with three ops in flight
    do_reset();
    while (cyc <= 20) begin
      case (cyc)
        1:       drive(1'b1, 3'd0, 2'd0, 1'b0);
        2:       drive(1'b1, 3'd1, 2'd1, 1'b0);
        3:       drive(1'b1, 3'd2, 2'd2, 1'b0);
        5:       drive(1'b1, 3'd5, 2'd0, 1'b1);
        6:       drive(1'b1, 3'd5, 2'd0, 1'b0);
        default: drive(1'b0, 3'd0, 2'd0, 1'b0);
      endcase
      smp();
      if (cyc <= 3) chk("fl_rdy_pre", bus.req_rdy, 1);
      if (cyc == 5) chk("fl_rdy5", bus.req_rdy, 0);
      if (cyc == 5) chk("fl_busy5", bus.busy, 8'h07);
      if (cyc == 6) chk("fl_busy6", bus.busy, 0);
      if (cyc == 6) chk("fl_rdy6", bus.req_rdy, 1);
      if (cyc == 6) chk("fl_iss6", bus.iss_v, 0);
      if (cyc == 7) chk("fl_iss7", {bus.iss_v, bus.iss_tid}, {1'b1, 3'd5});
      if (cyc >= 6) chk("fl_wb_v", bus.wb_v, (cyc == 15));
      if (cyc == 15) chk("fl_wb_tid", bus.wb_tid, 5);
      next_cyc();
    end

    // asynchronous reset with ops in flight
    do_reset();
    drive(1'b1, 3'd0, 2'd0, 1'b0);
    next_cyc();
    drive(1'b1, 3'd6, 2'd1, 1'b0);
    next_cyc();
    drive(1'b0, 3'd0, 2'd0, 1'b0);
    next_cyc();
    chk("rm_busy_pre", bus.busy, 8'h41);
    chk("rm_tid_pre",  bus.iss_tid, 6);
    #2;
    rst = 1'b1;
    #1;
    chk("rm_iss_v",   bus.iss_v,   0);
    chk("rm_iss_tid", bus.iss_tid, 0);
    chk("rm_iss_cls", bus.iss_cls, 0);
    chk("rm_busy",    bus.busy,    0);
    chk("rm_wb",      {bus.wb_v, bus.wb_tid}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 1;
    wb_cnt = 0;
    while (cyc <= 20) begin
      smp();
      if (bus.wb_v || bus.iss_v) wb_cnt++;
      next_cyc();
    end
    chk("rm_no_wb", wb_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
